soc_reset_sequencer: RTL and testbench



---
 rtl/soc_reset_sequencer.sv | 95 +++++++++
 tb/tb_soc_reset_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/soc_reset_sequencer.sv
// soc_reset_sequencer: debounced button reset with staged peripheral/CPU release; watchdog built only with SOC_RESET_WDT_EN
module soc_reset_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned STAGGER_CYCLES  = 256,
  parameter logic [31:0] WDT_CYCLES      = 32'd100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_resetn,
  input  logic       wdt_kick,
  output logic       periph_resetn,
  output logic       cpu_resetn,
  output logic [1:0] reset_cause,
  output logic       wdt_fired
);
  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CMAX = HOLD_CYCLES > STAGGER_CYCLES ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STAGGER_CYCLES - 1);
  typedef enum logic [1:0] {HOLD, PERIPH_UP, RUN} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic s, btn, expire;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] cause_nxt;
  assign s = sync[SYNC_STAGES-1];
  // bring the raw button into the clock domain
  always_ff @(posedge clk) sync <= rst ? '0 : {sync[SYNC_STAGES-2:0], ext_resetn};
  // adopt a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      btn  <= 1'b0;
      dcnt <= '0;
    end else if (s == btn || dcnt == D_LAST) begin
      btn  <= s;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end
  // next state, shared counter and reset cause; losing the button outranks watchdog expiry
  always_comb begin
    nxt       = state;
    cnt_nxt   = '0;
    cause_nxt = reset_cause;
    if (state != HOLD && !btn) begin
      nxt       = HOLD;
      cause_nxt = 2'b10;
    end else if (expire) begin
      nxt       = HOLD;
      cause_nxt = 2'b11;
    end else if (state == HOLD && btn) begin
      nxt     = cnt == H_LAST ? PERIPH_UP : HOLD;
      cnt_nxt = cnt == H_LAST ? '0 : cnt + 1'b1;
    end else if (state == PERIPH_UP) begin
      nxt     = cnt == S_LAST ? RUN : PERIPH_UP;
      cnt_nxt = cnt == S_LAST ? '0 : cnt + 1'b1;
    end
  end
  // state register and reset outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HOLD;
      cnt           <= '0;
      periph_resetn <= 1'b0;
      cpu_resetn    <= 1'b0;
      reset_cause   <= 2'b01;
    end else begin
      state         <= nxt;
      cnt           <= cnt_nxt;
      periph_resetn <= nxt != HOLD;
      cpu_resetn    <= nxt == RUN;
      reset_cause   <= cause_nxt;
    end
  end
`ifdef SOC_RESET_WDT_EN
  logic [31:0] wcnt;
  assign expire = state == RUN && btn && !wdt_kick && wcnt == WDT_CYCLES - 1;
  // watchdog counts RUN cycles since entry or the last kick
  always_ff @(posedge clk) begin
    wcnt      <= (rst || state != RUN || nxt != RUN || wdt_kick) ? '0 : wcnt + 1'b1;
    wdt_fired <= !rst && expire;
  end
`else
  logic unused_kick;
  assign unused_kick = wdt_kick;
  assign expire      = 1'b0;
  assign wdt_fired   = 1'b0;
`endif
endmodule

// File: tb/tb_soc_reset_sequencer.sv
// tb_soc_reset_sequencer: phase table, abort/watchdog sequences and random stimulus against a timing model
`timescale 1ns/1ps
module tb_soc_reset_sequencer;
  localparam int SYNC = 2, DEB = 4, HOLD = 8, STAG = 4, WDT = 20;
`ifdef SOC_RESET_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ext_resetn = 1'b1, wdt_kick = 1'b0;
  logic periph_resetn, cpu_resetn, wdt_fired;
  logic [1:0] reset_cause;
  int checks = 0, errors = 0, seg = 0;
  bit mon = 1'b0;
  soc_reset_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .STAGGER_CYCLES(STAG), .WDT_CYCLES(32'd20)
  ) dut (
    .clk(clk), .rst(rst), .ext_resetn(ext_resetn), .wdt_kick(wdt_kick),
    .periph_resetn(periph_resetn), .cpu_resetn(cpu_resetn),
    .reset_cause(reset_cause), .wdt_fired(wdt_fired)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] got();
    return {periph_resetn, cpu_resetn, reset_cause, wdt_fired};
  endfunction
  task automatic check(input string name, input logic [4:0] g, input logic [4:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s at %0t: got periph/cpu/cause/fired=%b/%b/%b/%b want %b/%b/%b/%b",
               name, $time, g[4], g[3], g[2:1], g[0], x[4], x[3], x[2:1], x[0]);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  // reference model: release timing from how long the debounced button has been high
  int t, w;
  logic bm, sm, pm, qm, fm, same, dummy;
  logic [1:0] cm;
  logic sq[$], win[$];
  always @(posedge clk) begin
    if (rst) begin
      t = 0; w = 0; bm = 0; sm = 0; pm = 0; qm = 0; fm = 0; cm = 2'b01;
      sq.delete(); win.delete();
      repeat (SYNC - 1) sq.push_back(1'b0);
      repeat (DEB) win.push_back(1'b0);
    end else begin
      fm = 0;
      if (!bm) begin
        if (pm) cm = 2'b10;
        t = 0;
      end else if (WDT_ON && qm && !wdt_kick && w == WDT - 1) begin
        fm = 1; cm = 2'b11; t = 0;
      end else if (t < HOLD + STAG) t++;
      w = (WDT_ON && qm && bm && !fm && !wdt_kick) ? w + 1 : 0;
      pm = t >= HOLD;
      qm = t >= HOLD + STAG;
      win.push_back(sm);
      dummy = win.pop_front();
      same = 1;
      foreach (win[i]) if (win[i] != win[0]) same = 0;
      if (same && win[0] != bm) bm = win[0];
      sq.push_back(ext_resetn);
      sm = sq.pop_front();
    end
  end
  always @(negedge clk) if (mon) check("model", got(), {pm, qm, cm, fm});
  typedef struct { string name; logic r, e, k; int n; logic [4:0] x; } phase_t;
  phase_t tbl[$];
  task automatic add(input string nm, input logic r, e, k, input int n, input logic [4:0] x);
    phase_t p;
    p.name = nm; p.r = r; p.e = e; p.k = k; p.n = n; p.x = x;
    tbl.push_back(p);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
  initial begin
    add("por_hold",     1, 1, 0, 3,  5'b00010);
    add("por_pre",      0, 1, 0, 13, 5'b00010);
    add("por_periph",   0, 1, 0, 1,  5'b10010);
    add("por_stagger",  0, 1, 0, 3,  5'b10010);
    add("por_cpu",      0, 1, 0, 1,  5'b11010);
    add("glitch",       0, 0, 0, 3,  5'b11010);
    add("glitch_after", 0, 1, 0, 10, 5'b11010);
    add("btn_pre",      0, 0, 0, 6,  5'b11010);
    add("btn_drop",     0, 0, 0, 1,  5'b00100);
    add("btn_held",     0, 0, 0, 3,  5'b00100);
    add("rel_pre",      0, 1, 0, 13, 5'b00100);
    add("rel_periph",   0, 1, 0, 1,  5'b10100);
    add("rel_stagger",  0, 1, 0, 3,  5'b10100);
    add("rel_cpu",      0, 1, 0, 1,  5'b11100);
    @(negedge clk);
    mon = 1'b1;
    foreach (tbl[i]) begin
      rst = tbl[i].r; ext_resetn = tbl[i].e; wdt_kick = tbl[i].k;
      step(tbl[i].n);
      check(tbl[i].name, got(), tbl[i].x);
    end
    ext_resetn = 0; step(10); check("abort_pressed", got(), 5'b00100);
    ext_resetn = 1; step(10);
    ext_resetn = 0; step(6); check("abort_periph_up", got(), 5'b10100);
    step(1); check("abort_drop", got(), 5'b00100);
    step(4);
    ext_resetn = 1; step(13); check("abort_rehold", got(), 5'b00100);
    step(1); check("abort_periph", got(), 5'b10100);
    step(3); check("abort_stagger", got(), 5'b10100);
    step(1); check("abort_cpu", got(), 5'b11100);
`ifdef SOC_RESET_WDT_EN
    step(19); check("wdt_pre", got(), 5'b11100);
    step(1); check("wdt_fire", got(), 5'b00111);
    step(1); check("wdt_pulse_end", got(), 5'b00110);
    step(6); check("wdt_rehold", got(), 5'b00110);
    step(1); check("wdt_periph", got(), 5'b10110);
    step(3); check("wdt_stagger", got(), 5'b10110);
    step(1); check("wdt_cpu", got(), 5'b11110);
    step(19);
    wdt_kick = 1; step(1); wdt_kick = 0;
    check("kick_expiry", got(), 5'b11110);
    for (int i = 0; i < 4; i++) begin
      step(18);
      wdt_kick = 1; step(1); wdt_kick = 0;
      check("kick_periodic", got(), 5'b11110);
    end
    step(10); check("kick_hold", got(), 5'b11110);
`else
    for (int i = 0; i < 60; i++) begin
      wdt_kick = $urandom_range(0, 1) == 1;
      step(1);
    end
    wdt_kick = 0;
    check("no_wdt", got(), 5'b11100);
`endif
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        ext_resetn = $urandom_range(0, 3) != 0;
        seg = ext_resetn ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 12));
      end
      seg--;
      wdt_kick = $urandom_range(0, 29) == 0;
      rst = $urandom_range(0, 799) == 0;
      step(1);
    end
    rst = 0; wdt_kick = 0;
    step(2);
    mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
